// File: rtl/branch_redirect_ctrl.sv
// Branch resolution / redirect controller: 2-bit BHT prediction for fetch,
// EX-stage training, and a flush + ready/valid redirect sequence on mispredict.
module branch_redirect_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_take_branch,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  output logic            ex_ready,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_d [BHT_ENTRIES];
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0]    rd_idx;
  logic [IDX-1:0]    wr_idx;
  logic              resolve;
  logic              actual;
  logic              mispredict;
  logic              unused_if_pc_bits;

  assign rd_idx            = if_pc[IDX+1:2];
  assign wr_idx            = ex_pc[IDX+1:2];
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};

  // Read path has no bypass: a write landing this edge is visible next cycle.
  assign pred_taken = bht_q[rd_idx][1];

  assign ex_ready   = (state_q == IDLE);
  assign resolve    = ex_valid & ex_ready & (ex_branch | ex_jump);
  assign actual     = ex_jump ? 1'b1 : ex_take_branch;
  assign mispredict = actual ^ ex_pred_taken;

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
      bht_d[i] = bht_q[i];
    end

    if (resolve && ex_branch && !ex_jump) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (ex_take_branch) begin
        if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'b01;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'b01;
      end
    end

    if (resolve && mispredict) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
      redirect_pc_d    = actual ? ex_target : ex_pc + XLEN'(4);
    end

    unique case (state_q)
      IDLE:     if (resolve && mispredict) state_d = FLUSH;
      FLUSH:    state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

  assign flush_if_id    = (state_q == FLUSH) || (state_q == REDIRECT);
  assign flush_id_ex    = flush_if_id;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
